// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter granting one shared memory port to four requesters, with a hold watchdog.
// Latency: request to grant 1 cycle; back-to-back re-grant on done with zero idle cycles.
// Backpressure: the owner keeps the port until done or watchdog expiry; other requests wait.
module mem_port_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [1:0] timeout_id_o
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam bit               WD_EN     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       timeout_id_q, timeout_id_d;

  logic       req_any;
  logic       wd_expire;
  logic [1:0] arb_ptr;
  logic [1:0] arb_idx;

  // First set bit of r, searching p+1, p+2, p+3, p (mod 4)
  function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    arb   = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        arb   = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign req_any   = |req_i;
  // Search starts after the last completed owner when idle, after the current owner when busy
  assign arb_ptr   = (state_q == S_IDLE) ? last_q : sel_q;
  assign arb_idx   = arb(req_i, arb_ptr);
  // done takes priority over expiry, so expiry is only considered without done
  assign wd_expire = WD_EN && (state_q == S_BUSY) && !done_i && (cnt_q == HOLD_LAST);

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 4'b0000;
      sel_q        <= 2'd0;
      last_q       <= 2'd3;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  // Next-state: grant from idle on any request, leave busy on done-without-request or expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_any) state_d = S_BUSY;
      S_BUSY: begin
        if (done_i) begin
          if (!req_any) state_d = S_IDLE;
        end else if (wd_expire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of grant, select, round-robin pointer, hold counter and timeout pulse
  always_comb begin
    grant_d      = grant_q;
    sel_d        = sel_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_d = 4'b0001 << arb_idx;
          sel_d   = arb_idx;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (done_i) begin
          last_d = sel_q;
          cnt_d  = '0;
          if (req_any) begin
            grant_d = 4'b0001 << arb_idx;
            sel_d   = arb_idx;
          end else begin
            grant_d = 4'b0000;
          end
        end else if (wd_expire) begin
          grant_d      = 4'b0000;
          last_d       = sel_q;
          cnt_d        = '0;
          timeout_d    = 1'b1;
          timeout_id_d = sel_q;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = 4'b0000;
      end
    endcase
  end

  assign grant_o      = grant_q;
  assign sel_o        = sel_q;
  assign busy_o       = (state_q == S_BUSY);
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Directed-vector bench for mem_port_arbiter4 with a watchdog hold limit of 8 cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed from the round-robin and watchdog rules.
module tb_mem_port_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] grant_o;
  logic [1:0] sel_o;
  logic       busy_o;
  logic       timeout_o;
  logic [1:0] timeout_id_o;

  int vec_cnt;
  int err_cnt;

  mem_port_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .done_i       (done_i),
    .grant_o      (grant_o),
    .sel_o        (sel_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .timeout_id_o (timeout_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({tag, ".grant"},   32'(grant_o),   32'(g));
    chk({tag, ".sel"},     32'(sel_o),     32'(s));
    chk({tag, ".busy"},    32'(busy_o),    32'(b));
    chk({tag, ".timeout"}, 32'(timeout_o), 32'(t));
  endtask

  logic [1:0] exp_sel [6];

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset held two cycles with all requests asserted
    rst_n  = 1'b0;
    req_i  = 4'b1111;
    done_i = 1'b0;
    step();
    chk_out("rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("rst_c1.tid", 32'(timeout_id_o), 32'd0);
    step();
    chk_out("rst_c2", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Release: first grant goes to requester 0, then done every cycle rotates 0,1,2,3,0,1
    rst_n = 1'b1;
    step();
    chk_out("rr_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    done_i = 1'b1;
    for (int i = 1; i < 6; i++) begin
      step();
      chk($sformatf("rr_sel%0d", i), 32'(sel_o), 32'(exp_sel[i]));
      chk($sformatf("rr_busy%0d", i), 32'(busy_o), 32'd1);
    end

    // done with no requests returns to idle; sel keeps last owner (1)
    req_i = 4'b0000;
    step();
    chk_out("rr_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // last=1, req=0101 -> requester 2 granted; then reset mid-transaction
    done_i = 1'b0;
    req_i  = 4'b0101;
    step();
    chk_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);

    // After reset the pointer is 3 again: 0101 -> 0, then done -> 2 with no idle gap
    rst_n = 1'b1;
    step();
    chk_out("p0101_a", 4'b0001, 2'd0, 1'b1, 1'b0);
    done_i = 1'b1;
    step();
    chk_out("p0101_b", 4'b0100, 2'd2, 1'b1, 1'b0);
    req_i = 4'b0000;
    step();
    chk_out("p0101_end", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Single requester 3 with done every cycle: re-granted back-to-back
    req_i = 4'b1000;
    step();
    chk_out("solo_g", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("solo_%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    req_i = 4'b0000;
    step();
    chk_out("solo_end", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Watchdog: requester 1 holds with no done for 8 cycles, then is released
    done_i = 1'b0;
    req_i  = 4'b0010;
    step();
    chk_out("wd_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_out($sformatf("wd_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    chk_out("wd_fire", 4'b0000, 2'd1, 1'b0, 1'b1);
    chk("wd_fire.tid", 32'(timeout_id_o), 32'd1);
    step();
    chk_out("wd_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Owner drops req: grant held until done
    req_i = 4'b0000;
    step();
    chk_out("drop_a", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    chk_out("drop_b", 4'b0010, 2'd1, 1'b1, 1'b0);
    done_i = 1'b1;
    step();
    chk_out("drop_done", 4'b0000, 2'd1, 1'b0, 1'b0);
    // done while idle changes nothing
    step();
    chk_out("idle_done", 4'b0000, 2'd1, 1'b0, 1'b0);

    // done coinciding with watchdog expiry: done wins, owner 1 re-granted, no timeout
    done_i = 1'b0;
    req_i  = 4'b0010;
    step();
    chk_out("coinc_g", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) step();
    chk_out("coinc_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
    done_i = 1'b1;
    step();
    chk_out("coinc_done", 4'b0010, 2'd1, 1'b1, 1'b0);
    done_i = 1'b0;
    step();
    chk_out("coinc_after", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter4.md
Name: mem_port_arbiter4

Overview:
- Round-robin arbiter that shares one memory/bus port among four requesters, e.g. IF fetch, LSU, debug, DMA.
- Drives the 2-bit select of the 4:1 data/address muxes in front of the port, plus a one-hot grant back to requesters.
- Holds ownership for a whole transaction until the port signals completion.
- A hold-limit watchdog forcibly releases a stalled owner.

Parameters:
- MAX_HOLD, 16, max cycles an owner may hold the port without done; 0 disables the watchdog.
- CNT_W, 8, width of the hold counter; MAX_HOLD must be < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req  input  4  request per requester; bit i = requester i.
- done  input  1  single-cycle completion pulse from the shared port for the current transaction.
- grant  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  binary index of the current owner, registered; drives the mux select.
- busy  output  1  high while a transaction is granted.
- timeout  output  1  one-cycle pulse when the watchdog releases an owner.
- timeout_id  output  2  owner index released by the watchdog; valid while timeout=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only at a rising edge of clk.
- Reset values: grant=0000, sel=00, busy=0, timeout=0, timeout_id=00, state=IDLE, last=3 (so the first search starts at requester 0), hold counter=0.
- Reset applied mid-transaction aborts it. There is no done handshake for the aborted owner.
- The arb function arb(r, p) returns the first set bit of r, searching p+1, p+2, p+3, p (mod 4). It is only evaluated when r is non-zero.

State IDLE:
- If req != 0, then at the next edge: owner = arb(req, last), grant = onehot(owner), sel = owner, busy = 1, counter = 0, state = BUSY.
- Latency from req high to grant is 1 cycle.
- done is ignored in IDLE.

State BUSY:
- grant and sel are held constant. req changes, including the owner dropping req, do not release the port.
- The counter increments each BUSY cycle, saturating.
- If done=1: last = owner. If req (sampled that cycle, owner bit included) != 0, re-arbitrate with arb(req, owner) and load the new grant at the same edge. There are zero idle cycles and state stays BUSY. Otherwise grant=0, busy=0, state=IDLE. The counter resets.
- An owner that is the only requester is re-granted back-to-back.
- Watchdog: if MAX_HOLD != 0, done=0 and counter == MAX_HOLD-1, then at the next edge:
  - grant=0, busy=0, state=IDLE, last=owner;
  - timeout=1 for exactly one cycle, timeout_id=owner.
  - There is no direct re-grant. Re-arbitration happens from IDLE on the following cycle.
- done and watchdog expiry in the same cycle: done wins and timeout stays 0.
- Invariants: grant is always zero or one-hot. sel equals the grant index when busy. sel retains its last value when idle.

Test Plan:
- Reset with req=1111 held low-reset for 2 cycles -> grant=0000, sel=0, busy=0 throughout. First grant after release is grant=0001.
- From IDLE, req=0101 -> next cycle grant=0001, sel=0. Pulse done -> next cycle grant=0100, sel=2 with busy staying 1. Drop req and pulse done -> grant=0000, busy=0.
- req=1111 held, done pulsed every cycle -> sel sequence 0,1,2,3,0,1.
- req=1000 only, done each cycle -> grant stays 1000 every cycle, busy never drops.
- MAX_HOLD=8, req=0010, no done -> granted 1 cycle later, held 8 cycles, then grant=0000 with timeout=1 and timeout_id=1 for one cycle. Re-granted to requester 1 on the next cycle.
- During BUSY, owner drops req and an done pulse arrives while idle -> grant held until done. The done while idle causes no state change. Reset asserted mid-BUSY -> all outputs return to reset values at the next edge.
